// File: rtl/cpu_control_unit.sv
// Instruction sequencer for the 8-bit microcontroller: fetch/decode/execute over a
// ready-handshaked memory bus, driving an external combinational ALU.
module cpu_control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    output logic [7:0] acc,
    output logic [7:0] pc,
    output logic       zero,
    output logic       halted
);

    typedef enum logic [2:0] {
        StStart,
        StFetch,
        StOperand,
        StRead,
        StWrite,
        StExec,
        StHalt
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] opr_q, opr_d;
    logic [7:0] mdr_q, mdr_d;
    logic       zero_q, zero_d;

    logic [3:0] opcode;
    logic [3:0] fetch_op;
    logic       fetch_two_byte;

    assign opcode   = ir_q[7:4];
    assign fetch_op = mem_rdata[7:4];
    // Opcodes 0x1-0x7 except ALUU (0x4) carry an operand byte.
    assign fetch_two_byte = (fetch_op >= 4'h1) && (fetch_op <= 4'h7) && (fetch_op != 4'h4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StStart;
            pc_q    <= RESET_PC;
            acc_q   <= 8'h00;
            ir_q    <= 8'h00;
            opr_q   <= 8'h00;
            mdr_q   <= 8'h00;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
            mdr_q   <= mdr_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        acc_d    = acc_q;
        ir_d     = ir_q;
        opr_d    = opr_q;
        mdr_d    = mdr_q;
        zero_d   = zero_q;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = pc_q;

        case (state_q)
            StStart: state_d = StFetch;
            StFetch: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 8'h01;
                    state_d = fetch_two_byte ? StOperand : StExec;
                end
            end
            StOperand: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    opr_d   = mem_rdata;
                    pc_d    = pc_q + 8'h01;
                    state_d = StFetch;
                    case (opcode)
                        4'h1, 4'h3: state_d = StRead;
                        4'h2:       state_d = StWrite;
                        4'h5:       pc_d = mem_rdata;
                        4'h6:       if (zero_q) pc_d = mem_rdata;
                        4'h7:       if (!zero_q) pc_d = mem_rdata;
                        default:    ;
                    endcase
                end
            end
            StRead: begin
                mem_rd   = 1'b1;
                mem_addr = opr_q;
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = StExec;
                end
            end
            StWrite: begin
                mem_wr   = 1'b1;
                mem_addr = opr_q;
                if (mem_ready) state_d = StFetch;
            end
            StExec: begin
                state_d = StFetch;
                case (opcode)
                    4'h1: begin
                        acc_d  = mdr_q;
                        zero_d = (mdr_q == 8'h00);
                    end
                    4'h3, 4'h4: begin
                        acc_d  = alu_result;
                        zero_d = alu_zero;
                    end
                    4'hF:    state_d = StHalt;
                    default: ;
                endcase
            end
            StHalt:  state_d = StHalt;
            default: state_d = StStart;
        endcase
    end

    assign alu_op    = ir_q[2:0];
    assign alu_a     = acc_q;
    assign alu_b     = (opcode == 4'h3) ? mdr_q : 8'h00;
    assign mem_wdata = acc_q;
    assign acc       = acc_q;
    assign pc        = pc_q;
    assign zero      = zero_q;
    assign halted    = (state_q == StHalt);

endmodule
